vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical pixel counters, the `x`/`y`/`active`/`vsync` raster signals consumed by `pattern_selector`, and the registered pad-side outputs `vga_hsync`, `vga_vsync`, `vga_rgb`. It drives the pattern path and closes the loop by sampling the 6-bit colour that `pattern_selector` returns for the current pixel. The block sits at the top of the video datapath, between the pixel-clock domain and the VGA connector pins.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels); H_TOTAL = 800
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
- `clk`  in  1  system clock; one clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pix_en`  in  1  pixel-advance enable; tie high when `clk` is the pixel clock
- `x`  out  10  current horizontal count, 0..799
- `y`  out  10  current vertical count, 0..524
- `active`  out  1  high when x < 640 and y < 480
- `vsync`  out  1  raw vertical sync, active-low, combinational from `y`
- `frame_start`  out  1  one-cycle strobe at the first pixel of a frame
- `rgb_in`  in  6  colour for (`x`,`y`) from `pattern_selector`, same cycle
- `vga_hsync`  out  1  registered hsync, active-low
- `vga_vsync`  out  1  registered vsync, active-low
- `vga_rgb`  out  6  registered colour, forced 0 during blanking

## Operation
- Two counters `h_cnt` (10 bit), `v_cnt` (10 bit); `x = h_cnt`, `y = v_cnt`.
- On a `clk` edge with `pix_en`=1: if `h_cnt` == H_TOTAL-1 then `h_cnt` <= 0 and `v_cnt` advances (wrapping V_TOTAL-1 -> 0); else `h_cnt` <= `h_cnt`+1. With `pix_en`=0 both counters and all registered outputs hold.
- `active`, `vsync`, `frame_start` are combinational decodes of the counters:
  - hsync low for `h_cnt` in [656, 751]; `vsync` low for `v_cnt` in [490, 491].
  - `frame_start` = `pix_en` & (`h_cnt`==0) & (`v_cnt`==0).
- Output stage, updated only on `pix_en` cycles:
  - `vga_rgb` <= `active` ? `rgb_in` : 6'b0
  - `vga_hsync` <= hsync decode
  - `vga_vsync` <= `vsync`
- Registered outputs therefore lag `x`/`y` by exactly one pixel, keeping sync and colour aligned at the pins.
- No other state; the frame structure is fixed by the parameters.

## Timing
- Reset (`rst` high at a `clk` edge, regardless of `pix_en`): `h_cnt`=0, `v_cnt`=0, `vga_hsync`=1, `vga_vsync`=1, `vga_rgb`=0. Immediately after reset `x`=0, `y`=0, `active`=1, `vsync`=1, and `frame_start`=`pix_en`.
- `rst` asserted mid-frame overrides counting on that edge; the next frame starts from (0,0) with no partial-line artefacts on the pads beyond the already-registered pixel.
- Line = 800 `pix_en` cycles; frame = 525 lines = 420000 `pix_en` cycles.
- `vsync` rising edge (the event `pattern_selector` counts) occurs when `v_cnt` goes 491 -> 492 at `h_cnt`=0: exactly once per frame.
- Pad latency: values decoded at count (h,v) appear on `vga_*` after the next `pix_en` edge.
- `rgb_in` is sampled only when `active`=1; its value during blanking is don't-care.

## Test plan
- Reset: hold `rst` 3 cycles with `pix_en`=1 -> `x`=0, `y`=0, `vga_hsync`=1, `vga_vsync`=1, `vga_rgb`=0; `frame_start`=1 on the first cycle after release.
- Line/frame counts: `pix_en`=1 for 420000 cycles -> `x` wraps 799->0 every 800 cycles; `y` wraps 524->0; `frame_start` pulses exactly once per 420000 cycles.
- Sync placement: `vga_hsync`=0 for exactly 96 consecutive cycles starting one cycle after `x`=656; `vga_vsync`=0 for 1600 cycles starting one cycle after (`x`=0,`y`=490).
- Blanking: drive `rgb_in`=6'b111111 constantly -> `vga_rgb`=6'b111111 only one cycle after `active`=1, else 0; `vga_rgb` is 0 at the pin cycle following `x`=640.
- Enable gating: `pix_en` toggling 1,0,1,0 -> counters advance every other cycle; all outputs hold on `pix_en`=0 cycles; frame = 840000 clocks.
- Mid-frame reset: assert `rst` at `x`=300,`y`=200 -> next cycle `x`=0,`y`=0, `vga_rgb`=0, `vga_hsync`=1, `vga_vsync`=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters, sync/active decodes and registered pad outputs.
// Pad outputs lag x/y by one pixel so sync and colour stay aligned at the connector.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       vsync,
    output logic       frame_start,
    input  logic [5:0] rgb_in,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [5:0] vga_rgb
);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] H_SBEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SEND = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] V_SBEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SEND = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] h_cnt, v_cnt;
    logic       hsync;

    always_comb begin
        x           = h_cnt;
        y           = v_cnt;
        active      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync       = !((h_cnt >= H_SBEG) && (h_cnt < H_SEND));
        vsync       = !((v_cnt >= V_SBEG) && (v_cnt < V_SEND));
        frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_rgb   <= '0;
        end else if (pix_en) begin
            h_cnt     <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            vga_hsync <= hsync;
            vga_vsync <= vsync;
            vga_rgb   <= active ? rgb_in : 6'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a full-size and a scaled-down instance against an arithmetic raster model.
// The scaled instance makes whole frames, vsync and frame wrap reachable in a short run.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_en = 1'b1;
    logic [5:0] rgb_in = 6'h3f;
    int vectors = 0;
    int miscompares = 0;

    logic [9:0] x_d, y_d, x_s, y_s;
    logic       act_d, vs_d, fs_d, vhs_d, vvs_d, act_s, vs_s, fs_s, vhs_s, vvs_s;
    logic [5:0] rgb_d, rgb_s;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x_d), .y(y_d), .active(act_d),
        .vsync(vs_d), .frame_start(fs_d), .rgb_in(rgb_in), .vga_hsync(vhs_d),
        .vga_vsync(vvs_d), .vga_rgb(rgb_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x_s), .y(y_s), .active(act_s),
        .vsync(vs_s), .frame_start(fs_s), .rgb_in(rgb_in), .vga_hsync(vhs_s),
        .vga_vsync(vvs_s), .vga_rgb(rgb_s)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
    } dec_t;

    // Raster position follows purely from how many pixels have elapsed since reset.
    function automatic dec_t dec(int n, int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
        dec_t d;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h = n % ht;
        int v = (n / ht) % vt;
        d.x   = 10'(h);
        d.y   = 10'(v);
        d.act = (h < ha) && (v < va);
        d.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
        d.vs  = !((v >= va + vf) && (v < va + vf + vs));
        return d;
    endfunction

    function automatic dec_t dec_d(int n);
        return dec(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic dec_t dec_s(int n);
        return dec(n, 8, 2, 3, 3, 6, 2, 2, 2);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    int         n_d = 0, n_s = 0;
    logic       m_hs_d = 1'b1, m_vs_d = 1'b1, m_hs_s = 1'b1, m_vs_s = 1'b1;
    logic [5:0] m_rgb_d = '0, m_rgb_s = '0;
    logic       started = 1'b0;

    always @(posedge clk) begin : model
        dec_t a, b;
        a = dec_d(n_d);
        b = dec_s(n_s);
        if (rst) begin
            started <= 1'b1;
            n_d <= 0; n_s <= 0;
            m_hs_d <= 1'b1; m_vs_d <= 1'b1; m_rgb_d <= '0;
            m_hs_s <= 1'b1; m_vs_s <= 1'b1; m_rgb_s <= '0;
        end else if (pix_en) begin
            n_d <= n_d + 1; n_s <= n_s + 1;
            m_hs_d <= a.hs; m_vs_d <= a.vs; m_rgb_d <= a.act ? rgb_in : 6'b0;
            m_hs_s <= b.hs; m_vs_s <= b.vs; m_rgb_s <= b.act ? rgb_in : 6'b0;
        end
    end

    always @(negedge clk) begin : compare
        dec_t a, b;
        if (started) begin
            a = dec_d(n_d);
            b = dec_s(n_s);
            chk("x", 32'(x_d), 32'(a.x));
            chk("y", 32'(y_d), 32'(a.y));
            chk("active", 32'(act_d), 32'(a.act));
            chk("vsync", 32'(vs_d), 32'(a.vs));
            chk("frame_start", 32'(fs_d), 32'(pix_en && a.x == 0 && a.y == 0));
            chk("vga_hsync", 32'(vhs_d), 32'(m_hs_d));
            chk("vga_vsync", 32'(vvs_d), 32'(m_vs_d));
            chk("vga_rgb", 32'(rgb_d), 32'(m_rgb_d));
            chk("s_x", 32'(x_s), 32'(b.x));
            chk("s_y", 32'(y_s), 32'(b.y));
            chk("s_active", 32'(act_s), 32'(b.act));
            chk("s_vsync", 32'(vs_s), 32'(b.vs));
            chk("s_frame_start", 32'(fs_s), 32'(pix_en && b.x == 0 && b.y == 0));
            chk("s_vga_hsync", 32'(vhs_s), 32'(m_hs_s));
            chk("s_vga_vsync", 32'(vvs_s), 32'(m_vs_s));
            chk("s_vga_rgb", 32'(rgb_s), 32'(m_rgb_s));
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        tick(3);
        rst = 1'b0;
        chk("lit_rst_x", 32'(x_d), 0);
        chk("lit_rst_y", 32'(y_d), 0);
        chk("lit_rst_hs", 32'(vhs_d), 1);
        chk("lit_rst_vs", 32'(vvs_d), 1);
        chk("lit_rst_rgb", 32'(rgb_d), 0);
        chk("lit_rst_active", 32'(act_d), 1);
        chk("lit_rst_fs", 32'(fs_d), 1);
        tick(640);
        chk("lit_x640", 32'(x_d), 640);
        chk("lit_x640_active", 32'(act_d), 0);
        chk("lit_x640_rgb", 32'(rgb_d), 32'h3f);
        tick(1);
        chk("lit_x641_rgb", 32'(rgb_d), 0);
        tick(16);
        chk("lit_x657_hs", 32'(vhs_d), 0);
        tick(95);
        chk("lit_x752_hs", 32'(vhs_d), 0);
        tick(1);
        chk("lit_x753_hs", 32'(vhs_d), 1);
        tick(47);
        chk("lit_line_x", 32'(x_d), 0);
        chk("lit_line_y", 32'(y_d), 1);
        chk("lit_s_x", 32'(x_s), 0);
        chk("lit_s_y", 32'(y_s), 2);
        for (int i = 0; i < 1200; i++) begin
            rgb_in = 6'($urandom);
            tick(1);
        end
        for (int i = 0; i < 800; i++) begin
            pix_en = i[0];
            rgb_in = 6'($urandom);
            tick(1);
        end
        pix_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (x_s == 10'd5 && y_s == 10'd4) found = 1'b1;
            else tick(1);
        end
        chk("mid_frame_reach", 32'(found), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("lit_mid_x", 32'(x_d), 0);
        chk("lit_mid_y", 32'(y_d), 0);
        chk("lit_mid_rgb", 32'(rgb_d), 0);
        chk("lit_mid_hs", 32'(vhs_d), 1);
        chk("lit_mid_vs", 32'(vvs_d), 1);
        chk("lit_mid_s_x", 32'(x_s), 0);
        chk("lit_mid_s_y", 32'(y_s), 0);
        tick(192);
        chk("lit_s_frame_x", 32'(x_s), 0);
        chk("lit_s_frame_y", 32'(y_s), 0);
        chk("lit_s_frame_fs", 32'(fs_s), 1);
        for (int i = 0; i < 300; i++) begin
            rgb_in = 6'($urandom);
            tick(1);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
